// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: shared types and constants for the MIPS multiply/divide unit.
// Revision 1.0
`default_nettype none

package mips_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_t;

  // Quotient reported for divide-by-zero; sliced down to the operand width.
  localparam logic [63:0] MD_DIV0_QUO = '1;

endpackage

`default_nettype wire

// File: rtl/mips_muldiv_unit_iter_core.sv
// muldiv_iter_core: one unsigned shift-add (multiply) or restoring-subtract (divide) step.
// Revision 1.0
`default_nettype none

module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh_rem;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    // Shifted remainder needs one extra bit; the difference always fits when non-negative.
    sh_rem = {acc_hi, acc_lo[WIDTH-1]};
    ge     = sh_rem >= {1'b0, operand};
    diff   = sh_rem[WIDTH-1:0] - operand;
    if (is_div) begin
      next_hi = ge ? diff : sh_rem[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], ge};
    end else begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU with start/busy/done handshake.
// Revision 1.0
`default_nettype none

module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   rs_data,
  input  logic [WIDTH-1:0]   rt_data,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_t        state, next_state;
  muldiv_op_t       op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_raw;
  logic             sa, sres, b_zero;

  logic             accept, signed_in, a_neg, b_neg, is_div_in, is_div_q;
  logic [WIDTH-1:0] a_mag, b_mag, nxt_hi, nxt_lo;
  logic [2*WIDTH-1:0] fixed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (cnt == '0) next_state = ST_FIX;
      ST_FIX:  next_state = ST_DONE;
      ST_DONE: next_state = start ? ST_RUN : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN) || (state == ST_FIX);
    done = (state == ST_DONE);
  end

  always_comb begin
    accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
    signed_in = ~op[0];
    is_div_in = op[1];
    a_neg     = signed_in & rs_data[WIDTH-1];
    b_neg     = signed_in & rt_data[WIDTH-1];
    a_mag     = a_neg ? -rs_data : rs_data;
    b_mag     = b_neg ? -rt_data : rt_data;
    is_div_q  = (op_q == MD_DIV) || (op_q == MD_DIVU);
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .is_div  (is_div_q),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (opnd),
    .next_hi (nxt_hi),
    .next_lo (nxt_lo)
  );

  // Divide-by-zero bypasses sign correction and reports the raw dividend.
  always_comb begin
    if (!is_div_q)
      fixed = sres ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    else if (b_zero)
      fixed = {a_raw, MD_DIV0_QUO[WIDTH-1:0]};
    else
      fixed = {(sa ? -acc_hi : acc_hi), (sres ? -acc_lo : acc_lo)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= MD_MULT;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      sa     <= 1'b0;
      sres   <= 1'b0;
      b_zero <= 1'b0;
      result <= '0;
    end else if (accept) begin
      op_q   <= muldiv_op_t'(op);
      cnt    <= CNT_W'(WIDTH - 1);
      acc_hi <= '0;
      acc_lo <= is_div_in ? a_mag : b_mag;
      opnd   <= is_div_in ? b_mag : a_mag;
      a_raw  <= rs_data;
      sa     <= a_neg;
      sres   <= a_neg ^ b_neg;
      b_zero <= (rt_data == '0);
    end else if (state == ST_RUN) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
      cnt    <= cnt - 1'b1;
    end else if (state == ST_FIX) begin
      result <= fixed;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: table-driven directed checks plus hand-written handshake sequences.
// Revision 1.0
`default_nettype none

module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;
  int edges, bcnt, dcnt;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[12];

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
    if (busy) bcnt++;
  endtask

  task automatic wait_done();
    while (!done && edges < 100) step();
  endtask

  // Issues a start at the next E0 and runs to the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    edges = 0; bcnt = 0;
    step();
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[3]  = '{2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E};
    vecs[4]  = '{2'b11, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
    vecs[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[7]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
    vecs[8]  = '{2'b10, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF};
    vecs[9]  = '{2'b01, 32'd0,         32'h1234_5678, 64'h0000_0000_0000_0000};
    vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF};
    vecs[11] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};

    reset = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    #1;
    chk("reset_busy",   64'(busy),   64'd0);
    chk("reset_done",   64'(done),   64'd0);
    chk("reset_result", result,      64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt);
      chk($sformatf("vec%0d_result", i),  result,           vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(edges),       64'd34);
      chk($sformatf("vec%0d_busy", i),    64'(bcnt),        64'd33);
      step();
      chk($sformatf("vec%0d_done_pulse", i), 64'(done),     64'd0);
    end

    // Start re-pulsed while busy must be ignored.
    @(negedge clk);
    op = 2'b01; rs_data = 32'd5; rt_data = 32'd6; start = 1'b1;
    edges = 0; bcnt = 0;
    step();
    start = 1'b0;
    repeat (4) step();
    @(negedge clk);
    rs_data = 32'd9; rt_data = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    chk("ignore_result",  result,     64'h1E);
    chk("ignore_latency", 64'(edges), 64'd34);

    // Start issued in the DONE cycle is accepted back-to-back.
    start = 1'b1; rs_data = 32'd9; rt_data = 32'd9;
    edges = 0; bcnt = 0;
    step();
    start = 1'b0;
    chk("b2b_busy",        64'(busy), 64'd1);
    chk("b2b_result_held", result,    64'h1E);
    wait_done();
    chk("b2b_result",  result,     64'h51);
    chk("b2b_latency", 64'(edges), 64'd34);

    // Asynchronous reset mid-RUN clears everything without a clock edge.
    run_op(2'b01, 32'd3, 32'd3);
    @(negedge clk);
    op = 2'b01; rs_data = 32'd3; rt_data = 32'd3; start = 1'b1;
    edges = 0; bcnt = 0;
    step();
    start = 1'b0;
    repeat (9) step();
    #2 reset = 1'b0;
    #1;
    chk("async_busy",   64'(busy), 64'd0);
    chk("async_done",   64'(done), 64'd0);
    chk("async_result", result,    64'd0);
    @(negedge clk);
    reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) dcnt++;
    end
    chk("post_reset_no_done", 64'(dcnt), 64'd0);
    chk("post_reset_idle",    64'(busy), 64'd0);
    chk("post_reset_result",  result,    64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
